// File: rtl/can_timing_pkg.sv
// Shared types and constants for the CAN bit-timing prescaler.
// Holds the divider FSM state encoding and the default counter width.
package can_timing_pkg;

   localparam int DEF_CNT_WIDTH = 16;

   typedef enum logic {
      STOP = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A prescale value P yields one time quantum every P+1 clock cycles.
   function automatic int tq_period(input int p);
      return p + 1;
   endfunction

endpackage

// File: rtl/prescale_counter.sv
// Divides the system clock by (prescale+1) into a one-cycle time-quantum pulse.
// The prescale value is shadowed and only reloaded at start, restart or quantum boundary.
module prescale_counter
   import can_timing_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] prescale,
   input  logic                 res_scale,
   output logic                 tq_en,
   output logic                 running,
   output logic [CNT_WIDTH-1:0] cnt_out
);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
   logic                 tq_q, tq_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= STOP;
         cnt_q    <= '0;
         shadow_q <= '0;
         tq_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         tq_q     <= tq_d;
      end
   end

   // Comparison is against the shadow copy only, so a mid-quantum write never
   // changes the length of the quantum already in progress.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      tq_d     = 1'b0;
      if (!en) begin
         state_d = STOP;
         cnt_d   = '0;
      end else if (state_q == STOP) begin
         state_d  = RUN;
         cnt_d    = '0;
         shadow_d = prescale;
      end else if (res_scale) begin
         cnt_d    = '0;
         shadow_d = prescale;
      end else if (cnt_q == shadow_q) begin
         tq_d     = 1'b1;
         cnt_d    = '0;
         shadow_d = prescale;
      end else begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      running = (state_q == RUN);
      tq_en   = tq_q;
      cnt_out = cnt_q;
   end

endmodule

// File: tb/tb_prescale_counter.sv
// Self-checking bench for prescale_counter: hand-derived per-cycle vectors
// checked through an expected-value queue, plus async-reset and long-period sequences.
module tb_prescale_counter;
   import can_timing_pkg::*;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         en;
   logic [W-1:0] prescale;
   logic         res_scale;
   logic         tq_en;
   logic         running;
   logic [W-1:0] cnt_out;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic         en;
      logic [W-1:0] prescale;
      logic         res;
      logic         tq;
      logic         run;
      logic [W-1:0] cnt;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   prescale_counter #(.CNT_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .prescale  (prescale),
      .res_scale (res_scale),
      .tq_en     (tq_en),
      .running   (running),
      .cnt_out   (cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic e, input int p, input logic r,
                               input logic t, input logic ru, input int c);
      vec_t v;
      v.en = e; v.prescale = W'(p); v.res = r;
      v.tq = t; v.run = ru; v.cnt = W'(c);
      vecs.push_back(v);
   endfunction

   task automatic check_output(input int idx);
      vec_t e;
      if (exp_q.size() == 0) begin
         compare($sformatf("queue_empty[%0d]", idx), 0, 1);
         return;
      end
      e = exp_q.pop_front();
      compare($sformatf("tq_en[%0d]", idx), int'(tq_en), int'(e.tq));
      compare($sformatf("running[%0d]", idx), int'(running), int'(e.run));
      compare($sformatf("cnt_out[%0d]", idx), int'(cnt_out), int'(e.cnt));
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      @(negedge clk);
      en        = v.en;
      prescale  = v.prescale;
      res_scale = v.res;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      check_output(idx);
   endtask

   initial begin
      int first_pulse;
      int second_pulse;

      // Rows: en, prescale, res_scale -> tq_en, running, cnt_out after the edge.
      // P=3: pulses at E0+4 and E0+8.
      add(1, 3, 0, 0, 1, 0);
      add(1, 3, 0, 0, 1, 1);
      add(1, 3, 0, 0, 1, 2);
      add(1, 3, 0, 0, 1, 3);
      add(1, 3, 0, 1, 1, 0);
      add(1, 3, 0, 0, 1, 1);
      add(1, 3, 0, 0, 1, 2);
      add(1, 3, 0, 0, 1, 3);
      add(1, 3, 0, 1, 1, 0);
      add(0, 3, 0, 0, 0, 0);
      // P=0: continuous enable from E0+1.
      add(1, 0, 0, 0, 1, 0);
      add(1, 0, 0, 1, 1, 0);
      add(1, 0, 0, 1, 1, 0);
      add(1, 0, 0, 1, 1, 0);
      // en=0 wins over res_scale.
      add(0, 0, 1, 0, 0, 0);
      // P=5, rewrite to 2 at cnt=1: this quantum stays 6, next is 3.
      add(1, 5, 0, 0, 1, 0);
      add(1, 5, 0, 0, 1, 1);
      add(1, 2, 0, 0, 1, 2);
      add(1, 2, 0, 0, 1, 3);
      add(1, 2, 0, 0, 1, 4);
      add(1, 2, 0, 0, 1, 5);
      add(1, 2, 0, 1, 1, 0);
      add(1, 2, 0, 0, 1, 1);
      add(1, 2, 0, 0, 1, 2);
      add(1, 2, 0, 1, 1, 0);
      // P=4, res_scale at cnt=3 then at terminal count, then held two cycles.
      add(0, 4, 0, 0, 0, 0);
      add(1, 4, 0, 0, 1, 0);
      add(1, 4, 0, 0, 1, 1);
      add(1, 4, 0, 0, 1, 2);
      add(1, 4, 0, 0, 1, 3);
      add(1, 4, 1, 0, 1, 0);
      add(1, 4, 0, 0, 1, 1);
      add(1, 4, 0, 0, 1, 2);
      add(1, 4, 0, 0, 1, 3);
      add(1, 4, 0, 0, 1, 4);
      add(1, 4, 0, 1, 1, 0);
      add(1, 4, 0, 0, 1, 1);
      add(1, 4, 0, 0, 1, 2);
      add(1, 4, 0, 0, 1, 3);
      add(1, 4, 0, 0, 1, 4);
      add(1, 4, 1, 0, 1, 0);
      add(1, 4, 1, 0, 1, 0);
      add(1, 4, 0, 0, 1, 1);
      // P=7, drop en at cnt=2, then restart: pulse at E0+8.
      add(0, 7, 0, 0, 0, 0);
      add(1, 7, 0, 0, 1, 0);
      add(1, 7, 0, 0, 1, 1);
      add(1, 7, 0, 0, 1, 2);
      add(0, 7, 0, 0, 0, 0);
      add(1, 7, 0, 0, 1, 0);
      for (int i = 1; i <= 7; i++) add(1, 7, 0, 0, 1, i);
      add(1, 7, 0, 1, 1, 0);
      // Set up P=0 so tq_en is high when reset hits.
      add(0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0);
      add(1, 0, 0, 1, 1, 0);

      rst       = 1'b0;
      en        = 1'b0;
      prescale  = '0;
      res_scale = 1'b0;
      #12;
      compare("reset_tq_en", int'(tq_en), 0);
      compare("reset_running", int'(running), 0);
      compare("reset_cnt_out", int'(cnt_out), 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

      // Asynchronous reset between edges while tq_en is high.
      compare("pre_reset_tq_en", int'(tq_en), 1);
      #2;
      rst = 1'b0;
      #1;
      compare("async_tq_en", int'(tq_en), 0);
      compare("async_running", int'(running), 0);
      compare("async_cnt_out", int'(cnt_out), 0);

      // Release with P=255 and en=1; the next edge is E0.
      @(negedge clk);
      prescale = W'(255);
      en       = 1'b1;
      rst      = 1'b1;
      #1;
      compare("release_running", int'(running), 0);
      @(posedge clk);
      #1;
      compare("e0_running", int'(running), 1);
      first_pulse  = -1;
      second_pulse = -1;
      for (int c = 1; c <= 600 && second_pulse < 0; c++) begin
         @(posedge clk);
         #1;
         if (tq_en) begin
            if (first_pulse < 0) first_pulse = c;
            else second_pulse = c;
         end
      end
      compare("p255_first_pulse", first_pulse, tq_period(255));
      compare("p255_period", second_pulse - first_pulse, tq_period(255));
      compare("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
